matrix_fifo_sched: RTL and testbench

Two-producer write arbiter and burst read scheduler for the 8-bit x 1024-entry matrix FIFO buffer in the YOLO feature-map path. It merges two pixel streams into the FIFO round-robin. It tracks FIFO occupancy internally and issues fixed-length read bursts to the downstream matrix builder. Write and read clocks of the FIFO are both driven from clk.

---
 rtl/matrix_fifo_sched.sv | 171 +++++++++++++++++
 tb/tb_matrix_fifo_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_fifo_sched.sv
// matrix_fifo_sched
// Merges two producer pixel streams round-robin into the 8-bit matrix FIFO of
// the YOLO feature-map path and schedules fixed-length read bursts from that
// FIFO towards the downstream matrix builder.
//
// Ports:
//   clk, tb_rst                     clock (both FIFO ports) / async active-high reset
//   s0_valid/s0_data/s0_ready       producer 0 handshake
//   s1_valid/s1_data/s1_ready       producer 1 handshake
//   fifo_wr_en/fifo_wr_data         FIFO write port, fifo_wr_full flag in
//   fifo_rd_en/fifo_rd_data         FIFO read port (data 1 cycle after rd_en), fifo_rd_empty in
//   m_ready                         downstream can accept a whole burst
//   m_valid/m_data/m_last           burst output stream
//   occupancy                       internally tracked FIFO word count
//   err_ovf/err_unf                 sticky overflow / underflow flags
module matrix_fifo_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_WIDTH = 10,
  parameter int BURST_LEN   = 16,
  parameter int HEADROOM    = 4
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic                   s0_valid,
  input  logic [DATA_WIDTH-1:0]  s0_data,
  output logic                   s0_ready,
  input  logic                   s1_valid,
  input  logic [DATA_WIDTH-1:0]  s1_data,
  output logic                   s1_ready,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_wr_data,
  input  logic                   fifo_wr_full,
  output logic                   fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic                   m_ready,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last,
  output logic [DEPTH_WIDTH:0]   occupancy,
  output logic                   err_ovf,
  output logic                   err_unf
);

  localparam int CW = DEPTH_WIDTH + 1;
  localparam logic [CW-1:0] WR_LIMIT  = CW'((2 ** DEPTH_WIDTH) - HEADROOM);
  localparam logic [CW-1:0] BURST_WDS = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] ZERO      = CW'(0);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   occ;
  logic [CW-1:0]   beat_cnt, beat_cnt_nxt;
  logic            rr_ptr;      // producer that wins when both are valid
  logic            grant0, grant1;
  logic            wr_ok;
  logic            rd_en;
  logic            last_beat;

  // Round-robin grant: single requester always wins, tie goes to rr_ptr.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (s0_valid && s1_valid) begin
      grant0 = ~rr_ptr;
      grant1 = rr_ptr;
    end else begin
      grant0 = s0_valid;
      grant1 = s1_valid;
    end
  end

  // Headroom keeps a few slots free to cover FIFO flag latency; reset blocks writes.
  assign wr_ok        = !tb_rst && (occ < WR_LIMIT) && !fifo_wr_full;
  assign s0_ready     = grant0 && wr_ok;
  assign s1_ready     = grant1 && wr_ok;
  assign fifo_wr_en   = s0_ready | s1_ready;
  assign fifo_wr_data = s1_ready ? s1_data : (s0_ready ? s0_data : {DATA_WIDTH{1'b0}});
  assign fifo_rd_en   = rd_en;
  assign occupancy    = occ;
  // FIFO has no output register; mask data outside valid beats.
  assign m_data       = m_valid ? fifo_rd_data : {DATA_WIDTH{1'b0}};

  // Round-robin pointer moves only on an accepted write.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      rr_ptr <= 1'b0;
    end else if (fifo_wr_en) begin
      rr_ptr <= s0_ready;
    end
  end

  // Occupancy counter; a simultaneous write and read cancel out.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      occ <= ZERO;
    end else begin
      case ({fifo_wr_en, rd_en})
        2'b10:   occ <= occ + ONE;
        2'b01:   occ <= (occ != ZERO) ? (occ - ONE) : occ;
        default: occ <= occ;
      endcase
    end
  end

  // Read FSM next state; empty mid-burst just stalls the burst without losing beats.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    rd_en        = 1'b0;
    last_beat    = 1'b0;
    case (state)
      IDLE: begin
        if ((occ >= BURST_WDS) && m_ready) begin
          state_nxt    = BURST;
          beat_cnt_nxt = ZERO;
        end else begin
          state_nxt    = IDLE;
        end
      end
      BURST: begin
        rd_en = !fifo_rd_empty;
        if (rd_en) begin
          beat_cnt_nxt = beat_cnt + ONE;
          if (beat_cnt == LAST_BEAT) begin
            last_beat = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = BURST;
          end
        end else begin
          state_nxt = BURST;
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = ZERO;
      end
    endcase
  end

  // Read FSM state and beat counter registers.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      state    <= IDLE;
      beat_cnt <= ZERO;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Output stream flags aligned with the FIFO read latency, plus sticky error flags.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      m_valid <= rd_en;
      m_last  <= last_beat;
      err_ovf <= err_ovf | (fifo_wr_en & fifo_wr_full);
      err_unf <= err_unf | (rd_en & fifo_rd_empty);
    end
  end

endmodule

// File: tb/tb_matrix_fifo_sched.sv
module tb_matrix_fifo_sched;

  logic        clk = 1'b0;
  logic        tb_rst;
  logic        s0_valid, s1_valid;
  logic [7:0]  s0_data, s1_data;
  logic        s0_ready, s1_ready;
  logic        fifo_wr_en, fifo_wr_full;
  logic [7:0]  fifo_wr_data, fifo_rd_data;
  logic        fifo_rd_en, fifo_rd_empty;
  logic        m_ready, m_valid, m_last;
  logic [7:0]  m_data;
  logic [10:0] occupancy;
  logic        err_ovf, err_unf;

  // FIFO model controls
  logic        force_empty, force_full;
  logic [7:0]  mem [0:1023];
  logic [9:0]  wptr, rptr;
  logic [10:0] cnt;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [7:0] exp_q [$];
  int beat_cyc [0:63];

  always #5 clk = ~clk;

  matrix_fifo_sched dut (
    .clk(clk), .tb_rst(tb_rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_full(fifo_wr_full),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .occupancy(occupancy), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  // Behavioural 1024-entry FIFO, read data registered one cycle after rd_en
  assign fifo_wr_full  = (cnt == 11'd1024) || force_full;
  assign fifo_rd_empty = (cnt == 11'd0) || force_empty;

  always @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wptr <= 10'd0;
      rptr <= 10'd0;
      cnt <= 11'd0;
      fifo_rd_data <= 8'd0;
    end else begin
      if (fifo_wr_en) begin
        mem[wptr] <= fifo_wr_data;
        wptr <= wptr + 10'd1;
      end
      if (fifo_rd_en) begin
        fifo_rd_data <= mem[rptr];
        rptr <= rptr + 10'd1;
      end
      cnt <= cnt + {10'd0, fifo_wr_en} - {10'd0, fifo_rd_en};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    tb_rst = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    s0_data = 8'd0; s1_data = 8'd0;
    m_ready = 1'b0; force_empty = 1'b0; force_full = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    tb_rst = 1'b0;
    @(negedge clk);
  endtask

  // Collect n output beats; optionally hold FIFO empty for 3 cycles once force_at beats seen
  task automatic collect(input int n, input int force_at, input int limit);
    int beats = 0;
    int fcnt = 0;
    logic [7:0] e;
    for (int c = 0; c < limit && beats < n; c++) begin
      @(negedge clk);
      if (m_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check("m_data", {24'd0, m_data}, {24'd0, e});
        check("m_last", {31'd0, m_last}, {31'd0, ((beats % 16) == 15)});
        beat_cyc[beats] = c;
        beats++;
      end
      force_empty = (force_at >= 0) && (beats >= force_at) && (fcnt < 3);
      if (force_empty) begin
        fcnt++;
        #1;
        check("rd_en_gap", {31'd0, fifo_rd_en}, 32'd0);
      end
    end
    force_empty = 1'b0;
    check("beat_count", beats, n);
  endtask

  initial begin
    int acc;
    int stall;
    logic any_mv;

    // Reset state
    tb_rst = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 8'h12; s1_data = 8'h34;
    m_ready = 1'b1; force_empty = 1'b0; force_full = 1'b0;
    #1;
    check("rst_s0_ready", {31'd0, s0_ready}, 32'd0);
    check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    check("rst_wr_data", {24'd0, fifo_wr_data}, 32'd0);
    check("rst_occ", {21'd0, occupancy}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_err", {30'd0, err_ovf, err_unf}, 32'd0);
    do_reset();

    // Producer 0 only, 20 words 0xFF downward, m_ready low
    any_mv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s0_valid = 1'b1;
      s0_data = 8'hFF - 8'(i);
      #1;
      check("s0_only_ready", {31'd0, s0_ready}, 32'd1);
      check("s0_only_data", {24'd0, fifo_wr_data}, {24'd0, 8'hFF - 8'(i)});
      any_mv |= m_valid;
      @(negedge clk);
    end
    s0_valid = 1'b0;
    #1;
    check("s0_only_occ", {21'd0, occupancy}, 32'd20);
    check("s0_only_no_mvalid", {31'd0, any_mv | m_valid}, 32'd0);
    check("s1_idle_ready", {31'd0, s1_ready}, 32'd0);

    // Both producers, alternation starting with AA
    do_reset();
    s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 8'hAA; s1_data = 8'h55;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("rr_wr_en", {31'd0, fifo_wr_en}, 32'd1);
      check("rr_data", {24'd0, fifo_wr_data}, (i % 2 == 0) ? 32'hAA : 32'h55);
      check("rr_s1_ready", {31'd0, s1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      exp_q.push_back((i % 2 == 0) ? 8'hAA : 8'h55);
      @(negedge clk);
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    #1;
    check("rr_occ", {21'd0, occupancy}, 32'd32);

    // Two back-to-back bursts of 16 from occupancy 32
    m_ready = 1'b1;
    collect(32, -1, 200);
    m_ready = 1'b0;
    check("burst_gap", {31'd0, (beat_cyc[16] - beat_cyc[15]) >= 2}, 32'd1);
    check("burst1_contig", beat_cyc[15] - beat_cyc[0], 32'd15);
    repeat (2) @(negedge clk);
    check("burst_occ_end", {21'd0, occupancy}, 32'd0);
    check("burst_m_valid_end", {31'd0, m_valid}, 32'd0);
    check("burst_err_unf", {31'd0, err_unf}, 32'd0);

    // Empty forced for 3 cycles mid-burst
    for (int i = 0; i < 16; i++) begin
      s0_valid = 1'b1; s0_data = 8'(i + 8'h40);
      exp_q.push_back(8'(i + 8'h40));
      @(negedge clk);
    end
    s0_valid = 1'b0;
    m_ready = 1'b1;
    collect(16, 5, 100);
    m_ready = 1'b0;
    check("empty_span", beat_cyc[15] - beat_cyc[0], 32'd18);
    repeat (2) @(negedge clk);
    check("empty_occ", {21'd0, occupancy}, 32'd0);
    check("empty_err_unf", {31'd0, err_unf}, 32'd0);
    check("empty_no_extra", {31'd0, m_valid}, 32'd0);

    // Reset at beat 8 of a burst
    for (int i = 0; i < 16; i++) begin
      s0_valid = 1'b1; s0_data = 8'(i);
      exp_q.push_back(8'(i));
      @(negedge clk);
    end
    s0_valid = 1'b0;
    m_ready = 1'b1;
    collect(8, -1, 100);
    tb_rst = 1'b1;
    #1;
    check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("mid_rst_m_last", {31'd0, m_last}, 32'd0);
    check("mid_rst_m_data", {24'd0, m_data}, 32'd0);
    check("mid_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("mid_rst_occ", {21'd0, occupancy}, 32'd0);
    @(negedge clk);
    tb_rst = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("post_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("post_rst_occ", {21'd0, occupancy}, 32'd0);
    m_ready = 1'b0;

    // FIFO full flag blocks writes
    s0_valid = 1'b1; s0_data = 8'h77; force_full = 1'b1;
    #1;
    check("full_s0_ready", {31'd0, s0_ready}, 32'd0);
    check("full_wr_en", {31'd0, fifo_wr_en}, 32'd0);
    @(negedge clk);
    force_full = 1'b0;

    // Fill until headroom limit
    acc = 0; stall = 0;
    for (int c = 0; c < 1100 && stall < 5; c++) begin
      s0_data = 8'(c);
      #1;
      if (s0_ready) acc++;
      else stall++;
      @(negedge clk);
    end
    #1;
    check("fill_accepted", acc, 32'd1020);
    check("fill_occ", {21'd0, occupancy}, 32'd1020);
    check("fill_ready", {31'd0, s0_ready}, 32'd0);
    check("fill_err_ovf", {31'd0, err_ovf}, 32'd0);
    s0_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
